trace_capture_buffer: RTL and testbench
=======================================

# trace_capture_buffer

Circular debug trace buffer for internal GPU signals such as PC, warp ID and active mask. It is the parametrised successor to the single-mode trace buffer.

- It adds a mask/value pattern trigger next to an external trigger.
- It adds a programmable post-trigger window, a sample qualifier, and status reporting.
- Readout uses a registered port indexed oldest-first.
- It sits beside an SM debug tap; a host/JTAG bridge reads it after `done`.

## Interface
- `DEPTH`, default 1024: entries; must be a power of two and at least 4.
- `WIDTH`, default 64: sample width in bits.
- `AW`, default `$clog2(DEPTH)`: address width; derived, not overridden.

- `clk  in  1`  single clock.
- `rst  in  1`  synchronous, active-high reset.
- `arm  in  1`  start a capture (level sampled each cycle).
- `abort  in  1`  return to IDLE from any state.
- `post_count  in  AW`  samples kept after the trigger sample; latched on arm.
- `trig_en  in  1`  enable the pattern trigger.
- `trig_mask  in  WIDTH`  pattern compare mask.
- `trig_value  in  WIDTH`  pattern compare value.
- `ext_trig  in  1`  external trigger, qualified by `sample_valid`.
- `sample_valid  in  1`  sample qualifier.
- `sample_in  in  WIDTH`  sample data.
- `state  out  2`  current FSM state.
- `done  out  1`  capture complete.
- `wrapped  out  1`  buffer has filled at least once this capture.
- `count  out  AW+1`  stored samples, saturating at DEPTH.
- `trig_idx  out  AW`  logical index of the trigger sample; valid in DONE.
- `rd_en  in  1`  read request.
- `rd_idx  in  AW`  logical read index; 0 is the oldest sample.
- `rd_valid  out  1`  read data valid.
- `rd_data  out  WIDTH`  read data.

## Operation
- FSM states: IDLE=0, PRE=1, POST=2, DONE=3.
- **Arm:**
  - `arm` in IDLE or DONE moves to PRE.
  - It clears `count`, `wrapped`, `done` and the write pointer, and latches `post_count`.
  - `arm` in PRE or POST is ignored.
- **Abort:** `abort` moves any state to IDLE and clears `done`. If `arm` and `abort` are high together, abort wins.
- **Accepted sample:** `sample_valid`=1 while in PRE or POST.
  - The sample is written at the write pointer, and the pointer advances modulo DEPTH.
  - `count` increments, saturating at DEPTH.
  - `wrapped` sets when the pointer wraps.
  - Cycles with `sample_valid`=0 write nothing.
- **Trigger hit:** `sample_valid` & (`ext_trig` | (`trig_en` & ((`sample_in` ^ `trig_value`) & `trig_mask`) == 0)). Only a hit in PRE has effect.
- **PRE + hit:**
  - The trigger sample is stored.
  - If the latched post is 0, go to DONE.
  - Otherwise go to POST with the remaining counter set to post.
- **POST:** each accepted sample decrements the remaining counter. The sample that brings it to 0 is stored, then the FSM goes to DONE. Further hits are ignored.
- **DONE:** no writes. `done`=1.
- **Bounds:**
  - `trig_idx` = `count` − 1 − latched post.
  - Post is at most DEPTH−1, so the trigger sample is always retained.
- **Read mapping:**
  - oldest = write pointer if `wrapped`, else 0.
  - physical address = (oldest + `rd_idx`) mod DEPTH.
  - If `rd_idx` ≥ `count`, then `rd_valid`=0 and `rd_data`=0.
- Reads are legal in any state. A read to the address being written in the same cycle returns the old content.

## Timing
- Reset values: `state`=IDLE; `done`, `wrapped`, `count`, `trig_idx`, `rd_valid` and `rd_data` are all 0. Memory contents are not cleared.
- A sample accepted in cycle N is readable from cycle N+1.
- `state` and `done` update on the edge after the final accepted sample.
- Read latency is 1 cycle: `rd_en` in cycle N gives `rd_valid`/`rd_data` in cycle N+1. Without `rd_en`, `rd_valid`=0 and `rd_data` holds its value.
- `rst` mid-capture gives IDLE on the next edge, with all status outputs zero.

## Structure
- **Package `trace_pkg`:**
  - State enum `trc_state_t` (TRC_IDLE, TRC_PRE, TRC_POST, TRC_DONE).
  - Trigger-match helper function.
- **Sub-module `trace_ram`:**
  - Simple dual-port memory, DEPTH × WIDTH.
  - One write port and a synchronous read port, so it infers block RAM.
- The FSM, pointers and counters live in the top level.

## Test plan
- **Wrapped capture:** DEPTH=16, post 4, trig_mask all ones, trig_value 30, samples 0..39 every cycle.
  - `done` after sample 34; `wrapped`=1; `count`=16; `trig_idx`=11.
  - `rd_idx` 0..15 returns 19..34.
- **Short pre-trigger:** post 3, `ext_trig` on sample 2 of 0,1,2,...
  - `count`=6, `wrapped`=0, `trig_idx`=2.
  - Reads return 0..5; `rd_idx` 6 gives `rd_valid`=0 and `rd_data`=0.
- **Immediate trigger:** post 0, `ext_trig` on the first sample 0xA5.
  - DONE the next cycle, `count`=1, `trig_idx`=0, read 0 returns 0xA5.
- **Qualifier gaps:** `sample_valid` toggled every cycle, 8 valid samples 10..17, no trigger.
  - `count`=8 and reads return 10..17 in order, without duplicates.
  - A hit asserted with `sample_valid`=0 has no effect.
- **Abort and reset:**
  - `abort` in POST gives IDLE with `done`=0.
  - `arm`+`abort` together gives IDLE.
  - `rst` in PRE clears all outputs.
  - Re-arm from DONE clears `count` to 0.
- **Read latency:** `rd_en` in a single cycle gives `rd_valid` high exactly one cycle later, then low.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and helpers for the debug trace capture buffer.
package trace_pkg;

    typedef enum logic [1:0] {
        TRC_IDLE = 2'd0,
        TRC_PRE  = 2'd1,
        TRC_POST = 2'd2,
        TRC_DONE = 2'd3
    } trc_state_t;

    // Widest sample the pattern helper supports; narrower samples are zero-extended.
    localparam int TRC_MAX_W = 512;

    function automatic logic trc_pattern_hit(
        input logic [TRC_MAX_W-1:0] sample,
        input logic [TRC_MAX_W-1:0] mask,
        input logic [TRC_MAX_W-1:0] value
    );
        return (((sample ^ value) & mask) == {TRC_MAX_W{1'b0}});
    endfunction

endpackage

// File: rtl/trace_capture_buffer_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
module trace_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port; a same-cycle write to this address is not visible until the next read.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/trace_capture_buffer.sv
// Circular trace buffer with pattern/external trigger, post-trigger window and oldest-first readout.
module trace_capture_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             abort,
    input  logic [AW-1:0]    post_count,
    input  logic             trig_en,
    input  logic [WIDTH-1:0] trig_mask,
    input  logic [WIDTH-1:0] trig_value,
    input  logic             ext_trig,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample_in,
    output logic [1:0]       state,
    output logic             done,
    output logic             wrapped,
    output logic [AW:0]      count,
    output logic [AW-1:0]    trig_idx,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_idx,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data
);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);

    trc_state_t    state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic          wrapped_q, wrapped_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] post_q, post_d;
    logic [AW-1:0] remain_q, remain_d;
    logic [AW-1:0] trig_idx_q, trig_idx_d;
    logic          done_q, done_d;
    logic          rd_valid_q, rd_zero_q;

    logic             accept_s, hit_s, we_s, in_range_s;
    logic [AW:0]      trig_full_s;
    logic [AW-1:0]    oldest_s, raddr_s;
    logic [WIDTH-1:0] ram_rdata_s;

    assign accept_s = sample_valid & ((state_q == TRC_PRE) | (state_q == TRC_POST));
    assign hit_s    = sample_valid & (ext_trig | (trig_en & trc_pattern_hit(TRC_MAX_W'(sample_in),
                                                                          TRC_MAX_W'(trig_mask),
                                                                          TRC_MAX_W'(trig_value))));

    // Capture FSM, write pointer and status counters.
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        wrapped_d   = wrapped_q;
        count_d     = count_q;
        post_d      = post_q;
        remain_d    = remain_q;
        trig_idx_d  = trig_idx_q;
        we_s        = 1'b0;
        trig_full_s = CNT_ZERO;

        if (abort) begin
            state_d = TRC_IDLE;
        end else if (arm && ((state_q == TRC_IDLE) || (state_q == TRC_DONE))) begin
            state_d    = TRC_PRE;
            wptr_d     = PTR_ZERO;
            wrapped_d  = 1'b0;
            count_d    = CNT_ZERO;
            post_d     = post_count;
            trig_idx_d = PTR_ZERO;
        end else if (accept_s) begin
            we_s      = 1'b1;
            wptr_d    = wptr_q + PTR_ONE;
            wrapped_d = wrapped_q | (wptr_q == PTR_LAST);
            count_d   = (count_q == CNT_FULL) ? count_q : (count_q + CNT_ONE);
            case (state_q)
                TRC_PRE: begin
                    if (hit_s) begin
                        state_d  = (post_q == PTR_ZERO) ? TRC_DONE : TRC_POST;
                        remain_d = post_q;
                    end else begin
                        state_d = TRC_PRE;
                    end
                end
                TRC_POST: begin
                    remain_d = remain_q - PTR_ONE;
                    state_d  = (remain_q == PTR_ONE) ? TRC_DONE : TRC_POST;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // Trigger position is fixed once the window closes: everything after it is the post window.
        trig_full_s = count_d - CNT_ONE - {1'b0, post_q};
        if ((state_d == TRC_DONE) && (state_q != TRC_DONE)) begin
            trig_idx_d = trig_full_s[AW-1:0];
        end else begin
            trig_idx_d = trig_idx_d;
        end

        done_d = (state_d == TRC_DONE);
    end

    // Capture state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TRC_IDLE;
            wptr_q     <= PTR_ZERO;
            wrapped_q  <= 1'b0;
            count_q    <= CNT_ZERO;
            post_q     <= PTR_ZERO;
            remain_q   <= PTR_ZERO;
            trig_idx_q <= PTR_ZERO;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            wrapped_q  <= wrapped_d;
            count_q    <= count_d;
            post_q     <= post_d;
            remain_q   <= remain_d;
            trig_idx_q <= trig_idx_d;
            done_q     <= done_d;
        end
    end

    assign oldest_s   = wrapped_q ? wptr_q : PTR_ZERO;
    assign raddr_s    = oldest_s + rd_idx;
    assign in_range_s = ({1'b0, rd_idx} < count_q);

    // Read qualifiers; rd_zero_q forces zero data for out-of-range reads and after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else if (rd_en) begin
            rd_valid_q <= in_range_s;
            rd_zero_q  <= ~in_range_s;
        end else begin
            rd_valid_q <= 1'b0;
            rd_zero_q  <= rd_zero_q;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (we_s),
        .waddr_i (wptr_q),
        .wdata_i (sample_in),
        .re_i    (rd_en & in_range_s),
        .raddr_i (raddr_s),
        .rdata_o (ram_rdata_s)
    );

    assign state    = state_q;
    assign done     = done_q;
    assign wrapped  = wrapped_q;
    assign count    = count_q;
    assign trig_idx = trig_idx_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_zero_q ? {WIDTH{1'b0}} : ram_rdata_s;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Scoreboard bench for trace_capture_buffer at DEPTH=16, WIDTH=16.
module tb_trace_capture_buffer;

    localparam int DEPTH = 16;
    localparam int WIDTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst, arm, abort, trig_en, ext_trig, sample_valid, rd_en;
    logic [AW-1:0]    post_count, rd_idx;
    logic [WIDTH-1:0] trig_mask, trig_value, sample_in;
    logic [1:0]       state;
    logic             done, wrapped, rd_valid;
    logic [AW:0]      count;
    logic [AW-1:0]    trig_idx;
    logic [WIDTH-1:0] rd_data;

    trace_capture_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .post_count(post_count),
        .trig_en(trig_en), .trig_mask(trig_mask), .trig_value(trig_value),
        .ext_trig(ext_trig), .sample_valid(sample_valid), .sample_in(sample_in),
        .state(state), .done(done), .wrapped(wrapped), .count(count),
        .trig_idx(trig_idx), .rd_en(rd_en), .rd_idx(rd_idx),
        .rd_valid(rd_valid), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: samples accepted since arm, and the expected FSM state.
    logic [WIDTH-1:0] model[$];
    int               m_state = 0;
    int               m_post = 0;
    int               m_remain = 0;
    logic             exp_v_q[$];
    logic [WIDTH-1:0] exp_d_q[$];
    logic [WIDTH-1:0] last_d;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic v, input logic [WIDTH-1:0] d, input logic e);
        logic hit;
        sample_valid = v;
        sample_in    = d;
        ext_trig     = e;
        hit = v && (e || (trig_en && (((d ^ trig_value) & trig_mask) == 16'h0000)));
        if (v && (m_state == 1 || m_state == 2)) begin
            model.push_back(d);
            if (m_state == 1) begin
                if (hit) begin
                    m_state  = (m_post == 0) ? 3 : 2;
                    m_remain = m_post;
                end
            end else begin
                m_remain--;
                if (m_remain == 0) m_state = 3;
            end
        end
        tick();
        sample_valid = 1'b0;
        ext_trig     = 1'b0;
        check_eq("state", state, m_state);
    endtask

    task automatic arm_capture(input int p);
        arm        = 1'b1;
        post_count = p[AW-1:0];
        tick();
        arm = 1'b0;
        model.delete();
        m_state = 1;
        m_post  = p;
        check_eq("arm_state", state, 1);
        check_eq("arm_count", count, 0);
        check_eq("arm_wrapped", wrapped, 0);
        check_eq("arm_done", done, 0);
    endtask

    task automatic issue_read(input int idx);
        int n, stored;
        n      = model.size();
        stored = (n > DEPTH) ? DEPTH : n;
        if (idx < stored) begin
            exp_v_q.push_back(1'b1);
            exp_d_q.push_back(model[n - stored + idx]);
        end else begin
            exp_v_q.push_back(1'b0);
            exp_d_q.push_back(16'h0000);
        end
        rd_en  = 1'b1;
        rd_idx = idx[AW-1:0];
    endtask

    task automatic compare_read();
        logic             ev;
        logic [WIDTH-1:0] ed;
        ev = exp_v_q.pop_front();
        ed = exp_d_q.pop_front();
        check_eq("rd_valid", rd_valid, ev);
        check_eq("rd_data", rd_data, ed);
        last_d = ed;
    endtask

    task automatic read_range(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            issue_read(i);
            tick();
            compare_read();
        end
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; post_count = 4'd0;
        trig_en = 1'b0; trig_mask = 16'h0000; trig_value = 16'h0000;
        ext_trig = 1'b0; sample_valid = 1'b0; sample_in = 16'h0000;
        rd_en = 1'b0; rd_idx = 4'd0; last_d = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_eq("rst_state", state, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_wrapped", wrapped, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_trig_idx", trig_idx, 0);
        check_eq("rst_rd_valid", rd_valid, 0);
        check_eq("rst_rd_data", rd_data, 0);

        // Wrapped capture: pattern trigger on 30, post 4.
        trig_en = 1'b1; trig_mask = 16'hFFFF; trig_value = 16'd30;
        arm_capture(4);
        for (int s = 0; s < 40; s++) send(1'b1, s[WIDTH-1:0], 1'b0);
        check_eq("wrap_done", done, 1);
        check_eq("wrap_wrapped", wrapped, 1);
        check_eq("wrap_count", count, 16);
        check_eq("wrap_trig_idx", trig_idx, 11);
        read_range(0, 15);
        check_eq("wrap_last_read", last_d, 34);

        // Short pre-trigger via ext_trig; re-arm from DONE clears count.
        trig_en = 1'b0;
        arm_capture(3);
        for (int s = 0; s < 6; s++) send(1'b1, s[WIDTH-1:0], (s == 2) ? 1'b1 : 1'b0);
        check_eq("short_done", done, 1);
        check_eq("short_count", count, 6);
        check_eq("short_wrapped", wrapped, 0);
        check_eq("short_trig_idx", trig_idx, 2);
        read_range(0, 6);

        // Single-cycle read: valid for exactly one cycle, data held afterwards.
        issue_read(2);
        tick();
        compare_read();
        rd_en = 1'b0;
        tick();
        check_eq("lat_valid_low", rd_valid, 0);
        check_eq("lat_data_hold", rd_data, 2);

        // Immediate trigger with post 0.
        arm_capture(0);
        send(1'b1, 16'h00A5, 1'b1);
        check_eq("imm_done", done, 1);
        check_eq("imm_count", count, 1);
        check_eq("imm_trig_idx", trig_idx, 0);
        read_range(0, 1);

        // Qualifier gaps, with ext_trig asserted only on invalid cycles.
        arm_capture(2);
        for (int k = 0; k < 8; k++) begin
            send(1'b0, 16'h00EE, 1'b1);
            send(1'b1, 16'(10 + k), 1'b0);
        end
        check_eq("gap_count", count, 8);
        check_eq("gap_done", done, 0);
        read_range(0, 8);

        // Abort in POST, then abort from DONE.
        send(1'b1, 16'h0020, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        m_state = 0;
        check_eq("abort_post_state", state, 0);
        check_eq("abort_post_done", done, 0);
        arm_capture(0);
        send(1'b1, 16'h0033, 1'b1);
        check_eq("pre_abort_done", done, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        m_state = 0;
        check_eq("abort_done_clr", done, 0);

        // arm and abort together.
        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        check_eq("arm_abort_state", state, 0);

        // Reset in PRE clears all status and read outputs.
        arm_capture(1);
        send(1'b1, 16'h0007, 1'b0);
        send(1'b1, 16'h0008, 1'b0);
        read_range(0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_state = 0;
        check_eq("rstmid_state", state, 0);
        check_eq("rstmid_done", done, 0);
        check_eq("rstmid_wrapped", wrapped, 0);
        check_eq("rstmid_count", count, 0);
        check_eq("rstmid_trig_idx", trig_idx, 0);
        check_eq("rstmid_rd_valid", rd_valid, 0);
        check_eq("rstmid_rd_data", rd_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
